// File: rtl/seq_pkg.sv
// seq_pkg: definitions shared by the serial transmit/detect blocks.
//   seq_state_t        : 2-bit state encoding (IDLE/SEND/GAP/DONE), also
//                        used by detector-side blocks.
//   IDLE_LEVEL_DEFAULT : line level driven when no frame bit is on the wire.
//   cnt_width()        : counter width able to hold 0..n-1 (never below 1).
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_gen_piso_shift.sv
// piso_shift: WIDTH-bit parallel-in, serial-out shift register.
//   clock, reset : rising-edge clock, synchronous active-high reset (clears)
//   load         : capture din (has priority over shift)
//   shift        : shift left by one, zero fill at the LSB
//   din          : parallel load value
//   msb          : current MSB, i.e. the bit being presented serially
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clock) begin
    if (reset) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter. On an accepted start the parallel
// frame is sent MSB-first, one bit per clock, repeat_n times (0 means 1),
// with GAP_CYCLES idle cycles between repeats.
//
// Handshake: start is a plain strobe sampled only in IDLE; while busy or in
// DONE it is dropped (never queued). bit_valid marks every cycle in which
// dout carries a frame bit; done pulses for one cycle after the last bit.
//
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : transmission request (IDLE only)
//   frame        : parallel frame, captured with start
//   repeat_n     : number of transmissions, captured with start
//   dout         : serial data, IDLE_LEVEL when no frame bit is driven
//   bit_valid    : dout carries a frame bit
//   busy         : high in SEND and GAP
//   done         : one-cycle completion pulse
//   state_dbg    : current FSM state, for observation
module seq_gen
  import seq_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   CNTW       = 4,
  parameter int   GAP_CYCLES = 1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] frame,
  input  logic [CNTW-1:0]  repeat_n,
  output logic             dout,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output seq_state_t       state_dbg
);

  localparam int BW = cnt_width(WIDTH);
  localparam int GW = cnt_width(GAP_CYCLES);
  localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  seq_state_t       state;
  logic [WIDTH-1:0] shadow;
  logic [BW-1:0]    bit_cnt;
  logic [CNTW-1:0]  rep_left;
  logic [GW-1:0]    gap_cnt;

  logic             last_bit;
  logic             more_reps;
  logic             sh_load;
  logic             sh_shift;
  logic [WIDTH-1:0] sh_din;
  logic             sh_msb;

  assign last_bit  = (state == SEND) && (bit_cnt == '0);
  assign more_reps = (rep_left > CNTW'(1));

  // The shift register is loaded from the live frame only on acceptance;
  // every later repeat reloads from the shadow copy so input changes
  // after capture cannot leak into the transmission.
  always_comb begin
    sh_load  = 1'b0;
    sh_shift = (state == SEND);
    sh_din   = shadow;
    if (state == IDLE && start) begin
      sh_load = 1'b1;
      sh_din  = frame;
    end else if (last_bit && more_reps && (GAP_CYCLES == 0)) begin
      sh_load = 1'b1;
    end else if (state == GAP && gap_cnt == '0) begin
      sh_load = 1'b1;
    end
  end

  piso_shift #(.WIDTH(WIDTH)) u_piso (
    .clock (clock),
    .reset (reset),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (sh_din),
    .msb   (sh_msb)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shadow    <= '0;
      bit_cnt   <= '0;
      rep_left  <= '0;
      gap_cnt   <= '0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shadow    <= frame;
            rep_left  <= (repeat_n == '0) ? CNTW'(1) : repeat_n;
            bit_cnt   <= BIT_LOAD;
            state     <= SEND;
            bit_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SEND: begin
          if (bit_cnt == '0) begin
            if (more_reps) begin
              rep_left <= rep_left - CNTW'(1);
              if (GAP_CYCLES > 0) begin
                state     <= GAP;
                gap_cnt   <= GAP_LOAD;
                bit_valid <= 1'b0;
              end else begin
                bit_cnt <= BIT_LOAD;
              end
            end else begin
              state     <= DONE;
              bit_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt - BW'(1);
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state     <= SEND;
            bit_cnt   <= BIT_LOAD;
            bit_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        DONE: begin
          // start is deliberately not looked at here
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          bit_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  assign dout      = (state == SEND) ? sh_msb : IDLE_LEVEL;
  assign state_dbg = state;

endmodule

// File: tb/tb_seq_gen.sv
module tb_seq_gen;
  import seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset = 1'b1;

  // DUT with one gap cycle
  logic       start1 = 1'b0;
  logic [7:0] frame1 = 8'h00;
  logic [3:0] rep1   = 4'd0;
  logic       dout1, valid1, busy1, done1;
  seq_state_t st1;

  // DUT with back-to-back repeats
  logic       start0 = 1'b0;
  logic [7:0] frame0 = 8'h00;
  logic [3:0] rep0   = 4'd0;
  logic       dout0, valid0, busy0, done0;
  seq_state_t st0;

  seq_gen #(.WIDTH(8), .CNTW(4), .GAP_CYCLES(1), .IDLE_LEVEL(1'b0)) dut_g1 (
    .clock(clock), .reset(reset), .start(start1), .frame(frame1), .repeat_n(rep1),
    .dout(dout1), .bit_valid(valid1), .busy(busy1), .done(done1), .state_dbg(st1)
  );

  seq_gen #(.WIDTH(8), .CNTW(4), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut_g0 (
    .clock(clock), .reset(reset), .start(start0), .frame(frame0), .repeat_n(rep0),
    .dout(dout0), .bit_valid(valid0), .busy(busy0), .done(done0), .state_dbg(st0)
  );

  // Reference Moore 101 detector (overlapping) fed by dut_g1.dout.
  logic [1:0] det_st;  // 0:none 1:"1" 2:"10" 3:"101"
  always @(posedge clock) begin
    if (reset) det_st <= 2'd0;
    else begin
      case (det_st)
        2'd0: det_st <= dout1 ? 2'd1 : 2'd0;
        2'd1: det_st <= dout1 ? 2'd1 : 2'd2;
        2'd2: det_st <= dout1 ? 2'd3 : 2'd0;
        default: det_st <= dout1 ? 2'd1 : 2'd2;
      endcase
    end
  end
  logic det_hit;
  assign det_hit = (det_st == 2'd3);

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic       start;
    logic [7:0] frame;
    logic [3:0] rep;
    logic       chk;
    logic       e_dout, e_valid, e_busy, e_done;
    logic       chk_det;
    logic       e_det;
  } vec_t;

  vec_t tbl[256];
  int   n_tbl = 0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic rst, input logic st, input logic [7:0] fr,
                     input logic [3:0] rp, input logic chk,
                     input logic d, input logic v, input logic b, input logic dn);
    tbl[n_tbl].rst     = rst;
    tbl[n_tbl].start   = st;
    tbl[n_tbl].frame   = fr;
    tbl[n_tbl].rep     = rp;
    tbl[n_tbl].chk     = chk;
    tbl[n_tbl].e_dout  = d;
    tbl[n_tbl].e_valid = v;
    tbl[n_tbl].e_busy  = b;
    tbl[n_tbl].e_done  = dn;
    tbl[n_tbl].chk_det = 1'b0;
    tbl[n_tbl].e_det   = 1'b0;
    n_tbl++;
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Eight frame bits; the frame/repeat inputs are scrambled meanwhile so a
  // design that failed to capture them would send the wrong bits.
  task automatic add_bits(input logic [7:0] fr);
    for (int i = 0; i < 8; i++) add(1'b0, 1'b0, ~fr, 4'd7, 1'b1, fr[7-i], 1'b1, 1'b1, 1'b0);
  endtask

  task automatic add_gap();
    add(1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic add_done();
    add(1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic build_table();
    int t0;
    // reset, then reset state observed
    add(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_idle(2);

    // single frame A5, with loopback detector hits at T+4 and T+9
    t0 = n_tbl;
    add(1'b0, 1'b1, 8'hA5, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_bits(8'hA5);
    add_done();
    add_idle(2);
    for (int k = t0; k <= t0 + 9; k++) begin
      tbl[k].chk_det = 1'b1;
      tbl[k].e_det   = (k == t0 + 4) || (k == t0 + 9);
    end

    // F0 x3 with one gap cycle, done at T+27
    add(1'b0, 1'b1, 8'hF0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_bits(8'hF0); add_gap();
    add_bits(8'hF0); add_gap();
    add_bits(8'hF0); add_done();
    add_idle(2);

    // repeat_n=0 acts as 1; starts at T+3 (busy) and T+9 (DONE) ignored
    t0 = n_tbl;
    add(1'b0, 1'b1, 8'hA5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_bits(8'hA5);
    add_done();
    add_idle(2);
    tbl[t0 + 3].start = 1'b1;
    tbl[t0 + 9].start = 1'b1;
    tbl[t0 + 9].frame = 8'hFF;
    tbl[t0 + 9].rep   = 4'd1;

    // reset during SEND at T+4, then a fresh frame from its MSB
    add(1'b0, 1'b1, 8'h3C, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    add_idle(1);
    add(1'b0, 1'b1, 8'hC3, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_bits(8'hC3);
    add_done();
    add_idle(3);
  endtask

  // ---------------- main ----------------
  initial begin
    build_table();

    for (int i = 0; i < n_tbl; i++) begin
      @(negedge clock);
      reset  = tbl[i].rst;
      start1 = tbl[i].start;
      frame1 = tbl[i].frame;
      rep1   = tbl[i].rep;
      #1;
      if (tbl[i].chk) begin
        n_vec++;
        if (dout1 !== tbl[i].e_dout || valid1 !== tbl[i].e_valid ||
            busy1 !== tbl[i].e_busy || done1 !== tbl[i].e_done ||
            (tbl[i].chk_det && det_hit !== tbl[i].e_det)) begin
          n_err++;
          $display("FAIL vec%0d dout/valid/busy/done/det got %b%b%b%b%b want %b%b%b%b%b",
                   i, dout1, valid1, busy1, done1, det_hit,
                   tbl[i].e_dout, tbl[i].e_valid, tbl[i].e_busy, tbl[i].e_done,
                   tbl[i].chk_det ? tbl[i].e_det : det_hit);
        end
      end
    end

    n_vec++;
    if (st1 !== IDLE) begin
      n_err++;
      $display("FAIL g1_final_state got %0d want %0d", st1, IDLE);
    end

    // back-to-back 81 x2 on the gapless instance: 16 valid cycles, done at T+17
    @(negedge clock);
    reset  = 1'b0;
    start0 = 1'b1;
    frame0 = 8'h81;
    rep0   = 4'd2;
    #1;
    n_vec++;
    if (busy0 !== 1'b0 || valid0 !== 1'b0 || done0 !== 1'b0) begin
      n_err++;
      $display("FAIL g0_start busy/valid/done got %b%b%b want 000", busy0, valid0, done0);
    end
    for (int c = 1; c <= 18; c++) begin
      logic [7:0] pat;
      logic e_d, e_v, e_b, e_dn;
      pat = 8'h81;
      @(negedge clock);
      start0 = 1'b0;
      frame0 = 8'h7E;
      rep0   = 4'd5;
      #1;
      e_d  = (c <= 16) ? pat[7 - ((c - 1) % 8)] : 1'b0;
      e_v  = (c <= 16);
      e_b  = (c <= 16);
      e_dn = (c == 17);
      n_vec++;
      if (dout0 !== e_d || valid0 !== e_v || busy0 !== e_b || done0 !== e_dn) begin
        n_err++;
        $display("FAIL g0_cycle%0d dout/valid/busy/done got %b%b%b%b want %b%b%b%b",
                 c, dout0, valid0, busy0, done0, e_d, e_v, e_b, e_dn);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
